// File: rtl/cim_shift_accumulator.sv
// ---------------------------------------------------------------------------
// cim_shift_accumulator
//
// Bit-serial shift-and-add stage that sits behind the CIM adder tree. Each
// accepted beat carries one input bit-plane partial sum per lane. Planes
// arrive MSB first. Each lane keeps acc = (acc << 1) + x. Optionally, the MSB
// plane is given negative weight so that signed inputs are handled. A
// finished group is copied into an output register, which is offered
// downstream with a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       beats per group: 0=4, 1=8, 2=16, 3=1 (bypass); taken on the
//              first beat of a group only
//   is_signed  MSB plane carries negative weight; taken on the first beat only
//   in_valid   in_data holds a bit-plane partial sum
//   in_ready   a beat is accepted this cycle when in_valid && in_ready
//   in_data    LANES signed lanes of IN_W bits, lane k at [k*IN_W +: IN_W]
//   out_valid  out_data holds a completed group
//   out_ready  downstream accepts out_data
//   out_data   LANES signed lanes of ACC_W bits, lane k at [k*ACC_W +: ACC_W]
//   busy       a group is partially accumulated
// ---------------------------------------------------------------------------
module cim_shift_accumulator #(
    parameter int LANES = 8,
    parameter int IN_W  = 36,
    parameter int ACC_W = 52
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     is_signed,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic                     busy
);

    localparam int CNT_W = 4;
    localparam int EXT_W = ACC_W - IN_W;

    // Index of the last beat of a group for a given precision mode.
    function automatic logic [CNT_W-1:0] last_index(input logic [1:0] m);
        logic [CNT_W-1:0] idx;
        case (m)
            2'd0:    idx = 4'd3;
            2'd1:    idx = 4'd7;
            2'd2:    idx = 4'd15;
            2'd3:    idx = 4'd0;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    // Group state
    logic [CNT_W-1:0]         cnt_r;
    logic [1:0]               mode_r;
    logic                     sign_r;
    logic [ACC_W-1:0]         acc_r [LANES];

    // Output register
    logic                     out_valid_r;
    logic [LANES*ACC_W-1:0]   out_data_r;
    logic                     busy_r;

    // Beat decode
    logic                     first_s;
    logic [1:0]               eff_mode_s;
    logic                     eff_sign_s;
    logic                     last_s;
    logic                     in_ready_s;
    logic                     accept_s;

    // Per-lane datapath
    logic [ACC_W-1:0]         x_s        [LANES];
    logic [ACC_W-1:0]         acc_next_s [LANES];
    logic [LANES*ACC_W-1:0]   acc_next_flat_s;

    // Beat decode. On the first beat, mode and sign come straight from the
    // inputs because the latched copies still belong to the previous group.
    always_comb begin
        first_s = (cnt_r == 4'd0);
        if (first_s) begin
            eff_mode_s = mode;
            eff_sign_s = is_signed;
        end else begin
            eff_mode_s = mode_r;
            eff_sign_s = sign_r;
        end
        last_s = (cnt_r == last_index(eff_mode_s));
        // Only a completing beat can collide with an unconsumed result.
        in_ready_s = !(last_s && out_valid_r && !out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Per-lane sign extension and shift-and-add, modulo 2^ACC_W.
    always_comb begin
        acc_next_flat_s = {(LANES*ACC_W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            x_s[k] = {{EXT_W{in_data[k*IN_W+IN_W-1]}}, in_data[k*IN_W +: IN_W]};
            if (first_s) begin
                if (eff_sign_s) begin
                    acc_next_s[k] = {ACC_W{1'b0}} - x_s[k];
                end else begin
                    acc_next_s[k] = x_s[k];
                end
            end else begin
                acc_next_s[k] = {acc_r[k][ACC_W-2:0], 1'b0} + x_s[k];
            end
            acc_next_flat_s[k*ACC_W +: ACC_W] = acc_next_s[k];
        end
    end

    // Accumulators, beat counter and the mode/sign latched at group start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 4'd0;
            mode_r <= 2'd0;
            sign_r <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_r[k] <= {ACC_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int k = 0; k < LANES; k++) begin
                acc_r[k] <= acc_next_s[k];
            end
            if (first_s) begin
                mode_r <= mode;
                sign_r <= is_signed;
            end else begin
                mode_r <= mode_r;
                sign_r <= sign_r;
            end
            if (last_s) begin
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end else begin
            cnt_r  <= cnt_r;
            mode_r <= mode_r;
            sign_r <= sign_r;
        end
    end

    // Output register and busy flag. A completion in the same cycle as a
    // consume reloads the register, so out_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {(LANES*ACC_W){1'b0}};
            busy_r      <= 1'b0;
        end else begin
            if (accept_s && last_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= acc_next_flat_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
                out_data_r  <= out_data_r;
            end else begin
                out_valid_r <= out_valid_r;
                out_data_r  <= out_data_r;
            end
            // busy mirrors (next count != 0).
            if (accept_s) begin
                busy_r <= !last_s;
            end else begin
                busy_r <= (cnt_r != 4'd0);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule
